// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of a 5-stage RISC-V pipeline. Owns the program
// counter, presents it as the byte address to a combinational instruction
// memory, and captures the returned word into the IF/ID pipeline register.
// It also handles hazard stalls, flushes, branch redirects and the halt that
// occurs when fetch runs off the end of the instruction memory.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   imem_addr      byte address to instruction memory (equals the PC register)
//   imem_instr     instruction word returned for imem_addr
//   stall          hold PC, IF/ID, fetch_count and state
//   flush          replace IF/ID with a bubble, PC holds
//   branch_taken   redirect fetch to branch_target (word aligned)
//   branch_target  redirect byte address
//   if_id_pc       PC of the instruction in IF/ID
//   if_id_instr    instruction in IF/ID
//   if_id_valid    IF/ID holds a real instruction (not a bubble)
//   halted         fetch is in the HALT state
//   fetch_count    saturating count of instructions latched valid into IF/ID
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter int unsigned IMEM_BYTES = 112,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    RUN,
    HALT
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] if_id_pc_d;
  logic [31:0] if_id_instr_d;
  logic        if_id_valid_d;
  logic [31:0] fetch_count_d;
  logic [63:0] target_aligned;

  // The range test is done in 65 bits so that a PC near 2^64 cannot wrap
  // around to a small value and look legal.
  function automatic logic in_range(input logic [63:0] addr);
    return ({1'b0, addr} + 65'd4) <= 65'(IMEM_BYTES);
  endfunction

  assign target_aligned = branch_target & ~64'd3;
  assign imem_addr      = pc_q;
  assign halted         = (state_q == HALT);

  // NOTE: every signal gets a hold/default value before the priority chain so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc;
    if_id_instr_d = if_id_instr;
    if_id_valid_d = if_id_valid;
    fetch_count_d = fetch_count;

    if (branch_taken) begin
      // Redirect wins over stall and flush, and may also leave HALT.
      pc_d          = target_aligned;
      if_id_pc_d    = '0;
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
      state_d       = in_range(target_aligned) ? RUN : HALT;
    end else if (flush) begin
      // PC holds, so the squashed address is fetched again next cycle.
      if_id_pc_d    = '0;
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
    end else if (stall) begin
      // Everything holds (defaults above).
    end else if (state_q == RUN && in_range(pc_q)) begin
      if_id_pc_d    = pc_q;
      if_id_instr_d = imem_instr;
      if_id_valid_d = 1'b1;
      pc_d          = pc_q + 64'd4;
      fetch_count_d = (fetch_count == '1) ? fetch_count : fetch_count + 32'd1;
    end else begin
      // Ran off the end of memory, or already halted: emit bubbles, PC holds.
      if_id_pc_d    = '0;
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
      state_d       = HALT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
      fetch_count <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      if_id_pc    <= if_id_pc_d;
      if_id_instr <= if_id_instr_d;
      if_id_valid <= if_id_valid_d;
      fetch_count <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed walk through the fetch scenarios followed by a randomized phase.
// A behavioural model of the fetch rules predicts every output after each
// clock edge; immediate assertions compare the DUT against it.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam int unsigned IMEM_BYTES = 112;
  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam int          NWORDS     = IMEM_BYTES / 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [NWORDS];

  // Reference model state
  logic [63:0] m_pc;
  logic [63:0] m_if_pc;
  logic [31:0] m_if_instr;
  logic        m_if_valid;
  logic        m_halted;
  logic [31:0] m_count;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC  (64'd0),
    .IMEM_BYTES(IMEM_BYTES),
    .NOP_INSTR (NOP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .stall        (stall),
    .flush        (flush),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid),
    .halted       (halted),
    .fetch_count  (fetch_count)
  );

  function automatic logic [31:0] imem_word(input logic [63:0] addr);
    if (addr < 64'(IMEM_BYTES)) return mem[addr[6:2]];
    return 32'hBADC_0DE0;
  endfunction

  assign imem_instr = imem_word(imem_addr);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_bubble();
    m_if_pc    = 64'd0;
    m_if_instr = NOP;
    m_if_valid = 1'b0;
  endtask

  // Apply one cycle of the fetch rules to the model, highest priority first.
  task automatic model_step(input logic r, input logic st, input logic fl,
                            input logic bt, input logic [63:0] tgt);
    logic [63:0] t;
    t = {tgt[63:2], 2'b00};
    if (r) begin
      m_pc = 64'd0; model_bubble(); m_count = 0; m_halted = 1'b0;
    end else if (bt) begin
      m_pc = t; model_bubble();
      m_halted = (t > 64'(IMEM_BYTES - 4));
    end else if (fl) begin
      model_bubble();
    end else if (st) begin
      // hold
    end else if (!m_halted && m_pc <= 64'(IMEM_BYTES - 4)) begin
      m_if_pc    = m_pc;
      m_if_instr = mem[m_pc[6:2]];
      m_if_valid = 1'b1;
      m_pc       = m_pc + 64'd4;
      if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
    end else begin
      model_bubble();
      m_halted = 1'b1;
    end
  endtask

  task automatic step(input logic r, input logic st, input logic fl,
                      input logic bt, input logic [63:0] tgt);
    reset = r; stall = st; flush = fl; branch_taken = bt; branch_target = tgt;
    model_step(r, st, fl, bt, tgt);
    @(posedge clk);
    #1;
    check("imem_addr",   imem_addr,          m_pc);
    check("if_id_pc",    if_id_pc,           m_if_pc);
    check("if_id_instr", 64'(if_id_instr),   64'(m_if_instr));
    check("if_id_valid", 64'(if_id_valid),   64'(m_if_valid));
    check("halted",      64'(halted),        64'(m_halted));
    check("fetch_count", 64'(fetch_count),   64'(m_count));
  endtask

  task automatic run();
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
  endtask

  task automatic run_to(input logic [63:0] target_pc);
    for (int i = 0; i < 64 && m_pc != target_pc; i++) run();
    check("run_to_pc", imem_addr, target_pc);
  endtask

  initial begin
    mem[0] = 32'h0050_0993;
    mem[1] = 32'h0734_0663;
    for (int i = 2; i < NWORDS; i++) mem[i] = $urandom;
    m_pc = '0; m_if_pc = '0; m_if_instr = NOP; m_if_valid = 0; m_halted = 0; m_count = 0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
    check("rst_instr", 64'(if_id_instr), 64'(NOP));

    // Free run: first two fetches
    run();
    check("e1_pc",    if_id_pc,            64'd0);
    check("e1_instr", 64'(if_id_instr),    64'h0050_0993);
    check("e1_valid", 64'(if_id_valid),    64'd1);
    check("e1_addr",  imem_addr,           64'd4);
    run();
    check("e2_pc",    if_id_pc,            64'd4);
    check("e2_instr", 64'(if_id_instr),    64'h0734_0663);
    check("e2_count", 64'(fetch_count),    64'd2);

    // Stall three cycles at PC 8
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
      check("stall_addr",  imem_addr,         64'd8);
      check("stall_ifpc",  if_id_pc,          64'd4);
      check("stall_count", 64'(fetch_count),  64'd2);
    end
    run();
    check("post_stall_pc", if_id_pc, 64'd8);

    // Branch with stall also high, misaligned target
    run_to(64'h40);
    step(1'b0, 1'b1, 1'b0, 1'b1, 64'h1A);
    check("br_addr",  imem_addr,         64'h18);
    check("br_instr", 64'(if_id_instr),  64'(NOP));
    check("br_valid", 64'(if_id_valid),  64'd0);
    run();
    check("br_fetch_pc",    if_id_pc,         64'h18);
    check("br_fetch_instr", 64'(if_id_instr), 64'(mem[6]));

    // Flush alone at PC 0x20
    run_to(64'h20);
    step(1'b0, 1'b0, 1'b1, 1'b0, 64'd0);
    check("fl_valid", 64'(if_id_valid), 64'd0);
    check("fl_addr",  imem_addr,        64'h20);
    run();
    check("fl_refetch_pc",    if_id_pc,         64'h20);
    check("fl_refetch_valid", 64'(if_id_valid), 64'd1);

    // Run off the end of memory
    run_to(64'h70);
    run();
    check("end_halted", 64'(halted),      64'd1);
    check("end_valid",  64'(if_id_valid), 64'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 64'd0);
    run();
    check("halt_hold_addr", imem_addr, 64'h70);

    // Redirect out of HALT, run to the end again, then branch out of range
    step(1'b0, 1'b0, 1'b0, 1'b1, 64'h64);
    check("resume_halted", 64'(halted), 64'd0);
    check("resume_addr",   imem_addr,   64'h64);
    for (int i = 0; i < 4; i++) run();
    check("rehalt", 64'(halted), 64'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 64'h200);
    check("oor_halted", 64'(halted), 64'd1);
    check("oor_addr",   imem_addr,   64'h200);
    // Target whose +4 would wrap past 2^64
    step(1'b0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    check("wrap_halted", 64'(halted), 64'd1);
    run();
    check("wrap_hold", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);

    // Reset mid-run with stall high
    step(1'b0, 1'b0, 1'b0, 1'b1, 64'h30);
    run();
    step(1'b1, 1'b1, 1'b0, 1'b0, 64'd0);
    check("mid_rst_addr",  imem_addr,         64'd0);
    check("mid_rst_count", 64'(fetch_count),  64'd0);
    check("mid_rst_halt",  64'(halted),       64'd0);

    // Randomized phase
    for (int i = 0; i < 600; i++) begin
      logic r, st, fl, bt;
      logic [63:0] tgt;
      r  = ($urandom_range(0, 99) < 2);
      st = ($urandom_range(0, 99) < 15);
      fl = ($urandom_range(0, 99) < 10);
      bt = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 9) == 0) tgt = {$urandom, $urandom};
      else tgt = 64'($urandom_range(0, 127));
      step(r, st, fl, bt, tgt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
